// File: rtl/alu_result_bcd_conv_pkg.sv
// rtl/alu_result_bcd_conv_pkg.sv - shared types and constants for the ALU result BCD converter
package alu_result_bcd_conv_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_DIGITS     = 3;
  localparam int WORK_WIDTH     = 4 * DEF_DIGITS + DEF_DATA_WIDTH;

  localparam logic [3:0] BCD_BLANK_NIBBLE = 4'hF;

endpackage

// File: rtl/alu_result_bcd_conv_bcd_add3.sv
// rtl/alu_result_bcd_conv_bcd_add3.sv - double-dabble nibble correction (+3 when nibble >= 5)
module bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  always_comb begin
    dout = din;
    if (din >= 4'd5) dout = din + 4'd3;
  end

endmodule

// File: rtl/alu_result_bcd_conv.sv
// rtl/alu_result_bcd_conv.sv - sequential shift-add-3 binary to packed BCD converter
// Optional: BCD_OVERFLOW_BLANK_EN writes all-F digits when the latched overflow is set.
module alu_result_bcd_conv
  import alu_result_bcd_conv_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DIGITS     = DEF_DIGITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] result,
  input  logic                  sign,
  input  logic                  overflow,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  sign_out,
  output logic                  overflow_out
);

  localparam int WW = 4 * DIGITS + DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH + 1);

  state_t          state;
  logic [WW-1:0]   work;
  logic [WW-1:0]   work_adj;
  logic [WW-1:0]   work_next;
  logic [CW-1:0]   count;
  logic [4*DIGITS-1:0] bcd_final;
  logic            unused_work_msb;

  // Correct every BCD nibble in parallel; the binary field passes straight through.
  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .din  (work[DATA_WIDTH + 4*g +: 4]),
      .dout (work_adj[DATA_WIDTH + 4*g +: 4])
    );
  end
  assign work_adj[DATA_WIDTH-1:0] = work[DATA_WIDTH-1:0];

  assign work_next       = {work_adj[WW-2:0], 1'b0};
  assign unused_work_msb = work_adj[WW-1];

`ifdef BCD_OVERFLOW_BLANK_EN
  assign bcd_final = overflow_out ? {DIGITS{BCD_BLANK_NIBBLE}}
                                  : work_next[WW-1 -: 4*DIGITS];
`else
  assign bcd_final = work_next[WW-1 -: 4*DIGITS];
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      work         <= '0;
      count        <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      bcd          <= '0;
      sign_out     <= 1'b0;
      overflow_out <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            work         <= {{(4*DIGITS){1'b0}}, result};
            sign_out     <= sign;
            overflow_out <= overflow;
            count        <= CW'(DATA_WIDTH);
            busy         <= 1'b1;
            state        <= SHIFT;
          end
        end
        SHIFT: begin
          work  <= work_next;
          count <= count - CW'(1);
          if (count == CW'(1)) begin
            bcd   <= bcd_final;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_result_bcd_conv.sv
// tb/tb_alu_result_bcd_conv.sv - directed self-checking bench for alu_result_bcd_conv
module tb_alu_result_bcd_conv;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  result = 8'd0;
  logic        sign = 1'b0;
  logic        overflow = 1'b0;
  logic        busy;
  logic        done;
  logic [11:0] bcd;
  logic        sign_out;
  logic        overflow_out;

  int total = 0;
  int bad   = 0;

  alu_result_bcd_conv dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .result       (result),
    .sign         (sign),
    .overflow     (overflow),
    .busy         (busy),
    .done         (done),
    .bcd          (bcd),
    .sign_out     (sign_out),
    .overflow_out (overflow_out)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    total++;
    if ({busy, done, bcd, sign_out, overflow_out} !== 16'h0) begin
      bad++;
      $display("FAIL reset_state: got busy=%b done=%b bcd=%h sign=%b ovf=%b, want all 0",
               busy, done, bcd, sign_out, overflow_out);
    end
    // Leave non-zero state behind, then reset asynchronously mid-cycle.
    result = 8'd255; sign = 1'b1; overflow = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; sign = 1'b0; overflow = 1'b0;
    repeat (10) @(negedge clk);
    result = 8'd77; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    total++;
    if ({busy, done, bcd, sign_out, overflow_out} !== 16'h0) begin
      bad++;
      $display("FAIL async_reset: got busy=%b done=%b bcd=%h sign=%b ovf=%b, want all 0",
               busy, done, bcd, sign_out, overflow_out);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_full_scale();
    @(negedge clk);
    result = 8'd255; start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      total++;
      if (busy !== (c <= 8) || done !== (c == 9)) begin
        bad++;
        $display("FAIL full_scale_timing cycle %0d: got busy=%b done=%b, want busy=%b done=%b",
                 c, busy, done, (c <= 8), (c == 9));
      end
    end
    total++;
    if (bcd !== 12'h255 || sign_out !== 1'b0 || overflow_out !== 1'b0) begin
      bad++;
      $display("FAIL full_scale_value: got bcd=%h sign=%b ovf=%b, want 255 0 0",
               bcd, sign_out, overflow_out);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  vin  [4] = '{8'd0, 8'd9, 8'd100, 8'd199};
    logic [11:0] vexp [4] = '{12'h000, 12'h009, 12'h100, 12'h199};
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      result = vin[k]; start = 1'b1;
      for (int c = 1; c <= 9; c++) begin
        @(negedge clk);
        if (c == 1) start = 1'b0;
        total++;
        if (busy !== (c <= 8) || done !== (c == 9)) begin
          bad++;
          $display("FAIL b2b_timing conv %0d cycle %0d: got busy=%b done=%b, want busy=%b done=%b",
                   k, c, busy, done, (c <= 8), (c == 9));
        end
      end
      total++;
      if (bcd !== vexp[k]) begin
        bad++;
        $display("FAIL b2b_value conv %0d: got bcd=%h, want %h", k, bcd, vexp[k]);
      end
    end
  endtask

  task automatic test_start_while_busy();
    @(negedge clk);
    result = 8'd123; start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (c == 3) begin result = 8'd45; start = 1'b1; end
      if (c == 4) start = 1'b0;
      total++;
      if (busy !== (c <= 8) || done !== (c == 9)) begin
        bad++;
        $display("FAIL busy_start_timing cycle %0d: got busy=%b done=%b, want busy=%b done=%b",
                 c, busy, done, (c <= 8), (c == 9));
      end
      if (c == 9) begin
        total++;
        if (bcd !== 12'h123) begin
          bad++;
          $display("FAIL busy_start_value: got bcd=%h, want 123", bcd);
        end
      end
    end
  endtask

  task automatic test_reset_mid_conversion();
    @(negedge clk);
    result = 8'd200; start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (c == 4) reset = 1'b1;
      if (c == 5) reset = 1'b0;
      #1;
      total++;
      if (done !== 1'b0 || (c >= 4 && (busy !== 1'b0 || bcd !== 12'h000))) begin
        bad++;
        $display("FAIL reset_abort cycle %0d: got busy=%b done=%b bcd=%h, want no done/busy, bcd 000",
                 c, busy, done, bcd);
      end
    end
    @(negedge clk);
    result = 8'd200; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    total++;
    if (done !== 1'b1 || bcd !== 12'h200) begin
      bad++;
      $display("FAIL reset_restart: got done=%b bcd=%h, want done=1 bcd=200", done, bcd);
    end
  endtask

  task automatic test_flags();
    logic [11:0] want;
`ifdef BCD_OVERFLOW_BLANK_EN
    want = 12'hFFF;
`else
    want = 12'h128;
`endif
    @(negedge clk);
    result = 8'd128; sign = 1'b1; overflow = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; sign = 1'b0; overflow = 1'b0; result = 8'd3;
    total++;
    if (sign_out !== 1'b1 || overflow_out !== 1'b1) begin
      bad++;
      $display("FAIL flags_latched: got sign=%b ovf=%b, want 1 1", sign_out, overflow_out);
    end
    repeat (8) @(negedge clk);
    total++;
    if (done !== 1'b1 || bcd !== want || sign_out !== 1'b1 || overflow_out !== 1'b1) begin
      bad++;
      $display("FAIL flags_value: got done=%b bcd=%h sign=%b ovf=%b, want 1 %h 1 1",
               done, bcd, sign_out, overflow_out, want);
    end
  endtask

  initial begin
    test_reset();
    test_full_scale();
    test_back_to_back();
    test_start_while_busy();
    test_reset_mid_conversion();
    test_flags();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_result_bcd_conv.md
Name: alu_result_bcd_conv

Overview:
Sequential binary-to-BCD converter (shift-add-3 / double dabble) that consumes the ALU's magnitude `result`, `sign` and `overflow` outputs.
- Produces packed BCD digits for the seven-segment display driver.
- Sits between the ALU and the display multiplexer.
- Uses a start/busy/done handshake, so the ALU output is sampled once per conversion.

Parameters:
- DATA_WIDTH, 8: width of the binary magnitude input.
- DIGITS, 3: number of BCD digits produced; must satisfy 10^DIGITS > 2^DATA_WIDTH − 1.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request a conversion; sampled only in IDLE.
- result  in  DATA_WIDTH  unsigned magnitude from the ALU (already two's-complement-negated for negative signed results).
- sign  in  1  ALU sign flag (1 = negative).
- overflow  in  1  ALU overflow/carry flag.
- busy  out  1  high while a conversion is in progress.
- done  out  1  single-cycle pulse when `bcd` is updated.
- bcd  out  4*DIGITS  packed BCD, digit 0 in bits [3:0].
- sign_out  out  1  `sign` latched at start.
- overflow_out  out  1  `overflow` latched at start.

Behaviour:
- Clock and reset: one clock domain (clk); reset is asynchronous and active-high.
- Reset values: state = IDLE; busy = 0, done = 0, bcd = 0, sign_out = 0, overflow_out = 0; internal shift register and counter cleared.
- Reset asserted mid-conversion aborts immediately. No done pulse is produced and `bcd` returns to 0.
- States: IDLE, SHIFT.
- IDLE:
  - On an edge with start = 1: load the working register with {DIGITS*4 zeros, result}, latch sign and overflow, set count = DATA_WIDTH, go to SHIFT.
  - With start = 0: hold.
- SHIFT, each edge performs one iteration:
  1. Every BCD nibble ≥ 5 gets +3 (combinational correction, in parallel on all nibbles).
  2. The whole working register shifts left by 1.
  3. count decrements.
- End of SHIFT: on the edge where count goes from 1 to 0, the shifted BCD field is written to `bcd`, done = 1 for that one cycle, and the state returns to IDLE.
- Outputs vs state:
  - busy = 1 exactly while in SHIFT (registered).
  - done is low in every other cycle.
- Latency: start high in cycle 0 → busy high in cycles 1..DATA_WIDTH → done high in cycle DATA_WIDTH+1 (cycle 9 at the defaults), with busy low in that cycle.
- start while busy: ignored. No queueing and no restart.
- start during the done cycle: accepted, because the state is IDLE. This gives back-to-back conversions at a throughput of one per DATA_WIDTH+1 cycles.
- `bcd`, `sign_out` and `overflow_out`:
  - `bcd` holds its value until the next completion.
  - `sign_out` and `overflow_out` update at the start edge.
- Input stability: `result` may change after the start edge without affecting the current conversion.
- Arithmetic: the working register is 4*DIGITS + DATA_WIDTH bits wide. Nibble correction is mod 16 and never exceeds 12 when the DIGITS constraint holds.

Optional Feature:
- Macro: BCD_OVERFLOW_BLANK_EN.
- Defined: if the latched overflow is 1, `bcd` is written with all nibbles = 4'hF at completion (the display decodes F as blank/error). The conversion still runs full length and done timing is unchanged.
- Undefined: `bcd` is always the converted value; overflow is only reported via `overflow_out`.

Decomposition:
- Shared package contents:
  - state enum {IDLE, SHIFT}
  - default DATA_WIDTH and DIGITS constants
  - BCD_BLANK_NIBBLE = 4'hF
  - derived WORK_WIDTH = 4*DIGITS + DATA_WIDTH
- Sub-module `bcd_add3`: combinational, 4-bit in → 4-bit out, adds 3 when input ≥ 5. Instantiated DIGITS times via generate.

Test Plan:
1. Reset: assert reset asynchronously mid-cycle → busy = 0, done = 0, bcd = 12'h000, sign_out = 0, overflow_out = 0 immediately.
2. Full-scale conversion: result = 8'd255, start pulse in cycle 0 → busy high in cycles 1–8, done high in cycle 9 only, bcd = 12'h255.
3. Corner values, run back-to-back by reasserting start in each done cycle → no idle gap and exactly one done per conversion:
   - result = 8'd0 → 12'h000
   - result = 8'd9 → 12'h009
   - result = 8'd100 → 12'h100
   - result = 8'd199 → 12'h199
4. Start while busy: start with result = 123, then start with result = 45 in cycle 3 → one done in cycle 9 with bcd = 12'h123 and no second done.
5. Reset mid-conversion: start with result = 200, assert reset in cycle 4, release it in cycle 5 → no done, bcd = 0; a fresh start then yields 12'h200.
6. Flags: result = 8'd128, sign = 1, overflow = 1 → sign_out = 1 and overflow_out = 1 from cycle 1.
   - Macro undefined: bcd = 12'h128.
   - BCD_OVERFLOW_BLANK_EN defined: bcd = 12'hFFF.
